// File: rtl/core_pkg.sv
// core_pkg: shared types and constants for the RV32I core.
// Holds the data-memory FSM states, funct3 width codes and the default watchdog limit.
package core_pkg;

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      WAIT,
      DONE
   } dmem_state_t;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   localparam int TO_CYCLES_DEF = 255;

   // Low funct3 bits give the access size: 01 half, 10 word.
   function automatic logic misaligned(
      input logic [1:0] sz,
      input logic [1:0] off
   );
      return ((sz == 2'b01) && off[0]) ||
             ((sz == 2'b10) && (off != 2'b00));
   endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// dmem_lane_align: byte-lane steering for stores and lane extract/extend for loads.
// Ports: funct3/offset select size and lane; st_* store path; ld_* load path. Combinational.
module dmem_lane_align
   import core_pkg::*;
(
   input  logic [2:0]  funct3,
   input  logic [1:0]  offset,
   input  logic        is_store,
   input  logic [31:0] st_data,
   output logic [31:0] st_word,
   output logic [3:0]  st_strb,
   input  logic [31:0] ld_word,
   output logic [31:0] ld_data
);

   logic [31:0] shifted;

   always_comb begin
      st_word = st_data;
      st_strb = 4'b0000;
      if (is_store) begin
         unique case (funct3[1:0])
            2'b00: begin
               st_word = {4{st_data[7:0]}};
               st_strb = 4'b0001 << offset;
            end
            2'b01: begin
               st_word = {2{st_data[15:0]}};
               st_strb = offset[1] ? 4'b1100 : 4'b0011;
            end
            default: st_strb = 4'b1111;
         endcase
      end
   end

   assign shifted = ld_word >> {offset, 3'b000};

   always_comb begin
      ld_data = ld_word;
      unique case (funct3)
         F3_B:  ld_data = {{24{shifted[7]}}, shifted[7:0]};
         F3_BU: ld_data = {24'h0, shifted[7:0]};
         F3_H:  ld_data = {{16{shifted[15]}}, shifted[15:0]};
         F3_HU: ld_data = {16'h0, shifted[15:0]};
         default: ld_data = ld_word;
      endcase
   end

endmodule

// File: rtl/dmem_access_unit.sv
// dmem_access_unit: MEM-stage data-memory controller; valid/ready request, pipeline freeze,
// store steering and load alignment. Ports: EX/MEM controls in, DMem_* bus, MemStall/
// MemRData/MisalignErr to pipeline. Optional watchdog: define DMEM_TIMEOUT_EN.
module dmem_access_unit
   import core_pkg::*;
#(
   parameter int ADDR_W    = 32,
   parameter int DATA_W    = 32,
   parameter int TO_CYCLES = TO_CYCLES_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ExMem_MemRead,
   input  logic              ExMem_MemWrite,
   input  logic [2:0]        ExMem_Funct3,
   input  logic [ADDR_W-1:0] ExMem_Addr,
   input  logic [DATA_W-1:0] ExMem_WData,
   output logic              DMem_Req,
   input  logic              DMem_Ready,
   output logic              DMem_We,
   output logic [ADDR_W-1:0] DMem_Addr,
   output logic [DATA_W-1:0] DMem_WData,
   output logic [3:0]        DMem_WStrb,
   input  logic              DMem_RValid,
   input  logic [DATA_W-1:0] DMem_RData,
   output logic              MemStall,
   output logic [DATA_W-1:0] MemRData,
   output logic              MisalignErr
);

   dmem_state_t state, nxt;

   logic              acc, mis, start, we_in, req, from_in;
   logic              we_q, to_hit, to_err;
   logic [2:0]        f3_q, f3_sel;
   logic [1:0]        off_q, off_sel;
   logic [3:0]        wstrb_q, st_strb;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q, rdata_q, st_word, ld_data;

   assign acc     = ExMem_MemRead | ExMem_MemWrite;
   assign we_in   = ExMem_MemWrite & ~ExMem_MemRead;
   assign mis     = acc & misaligned(ExMem_Funct3[1:0], ExMem_Addr[1:0]);
   assign start   = acc & ~mis & ~rst;
   assign from_in = (state == IDLE);

   // Outside IDLE the load extract must use the fields latched at issue.
   assign f3_sel  = from_in ? ExMem_Funct3 : f3_q;
   assign off_sel = from_in ? ExMem_Addr[1:0] : off_q;

   dmem_lane_align u_align (
      .funct3   (f3_sel),
      .offset   (off_sel),
      .is_store (we_in),
      .st_data  (ExMem_WData),
      .st_word  (st_word),
      .st_strb  (st_strb),
      .ld_word  (DMem_RData),
      .ld_data  (ld_data)
   );

`ifdef DMEM_TIMEOUT_EN
   logic [7:0] cnt;
   logic       to_q;

   assign to_hit = ((state == REQ  && !DMem_Ready) ||
                    (state == WAIT && !DMem_RValid)) &&
                   (cnt == 8'(TO_CYCLES - 1));
   assign to_err = to_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt  <= '0;
         to_q <= 1'b0;
      end else begin
         to_q <= to_hit;
         if (nxt != state)
            cnt <= '0;
         else if (state == REQ || state == WAIT)
            cnt <= cnt + 8'd1;
      end
   end
`else
   assign to_hit = 1'b0;
   assign to_err = 1'b0;
`endif

   always_comb begin
      nxt = state;
      req = 1'b0;
      unique case (state)
         IDLE: if (start) begin
            req = 1'b1;
            nxt = DMem_Ready ? WAIT : REQ;
         end
         REQ: begin
            req = 1'b1;
            if (DMem_Ready)  nxt = WAIT;
            else if (to_hit) nxt = DONE;
         end
         WAIT: if (DMem_RValid || to_hit) nxt = DONE;
         DONE: nxt = IDLE;
         default: nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         addr_q  <= '0;
         wdata_q <= '0;
         wstrb_q <= '0;
         we_q    <= 1'b0;
         f3_q    <= '0;
         off_q   <= '0;
         rdata_q <= '0;
      end else begin
         state <= nxt;
         if (from_in && start) begin
            addr_q  <= {ExMem_Addr[ADDR_W-1:2], 2'b00};
            wdata_q <= st_word;
            wstrb_q <= st_strb;
            we_q    <= we_in;
            f3_q    <= ExMem_Funct3;
            off_q   <= ExMem_Addr[1:0];
         end
         // Result lives only in DONE so idle and error cycles retire zero.
         if (state == WAIT && DMem_RValid)
            rdata_q <= we_q ? '0 : ld_data;
         else if (state == DONE || to_hit)
            rdata_q <= '0;
      end
   end

   assign DMem_Req    = req;
   assign DMem_We     = req & (from_in ? we_in : we_q);
   assign DMem_Addr   = !req ? '0 :
                        from_in ? {ExMem_Addr[ADDR_W-1:2], 2'b00} : addr_q;
   assign DMem_WData  = !req ? '0 : from_in ? st_word : wdata_q;
   assign DMem_WStrb  = !req ? '0 : from_in ? st_strb : wstrb_q;
   assign MemStall    = start & (state != DONE);
   assign MemRData    = rdata_q;
   assign MisalignErr = (from_in & mis & ~rst) | to_err;

endmodule

// File: tb/tb_dmem_access_unit.sv
// tb_dmem_access_unit: directed checks of dmem_access_unit handshake, stall and lanes.
// Inputs change on the falling edge; outputs are checked 1 time unit later.
module tb_dmem_access_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        ExMem_MemRead, ExMem_MemWrite;
   logic [2:0]  ExMem_Funct3;
   logic [31:0] ExMem_Addr, ExMem_WData;
   logic        DMem_Req, DMem_Ready, DMem_We;
   logic [31:0] DMem_Addr, DMem_WData;
   logic [3:0]  DMem_WStrb;
   logic        DMem_RValid;
   logic [31:0] DMem_RData;
   logic        MemStall;
   logic [31:0] MemRData;
   logic        MisalignErr;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   dmem_access_unit dut (
      .clk            (clk),
      .rst            (rst),
      .ExMem_MemRead  (ExMem_MemRead),
      .ExMem_MemWrite (ExMem_MemWrite),
      .ExMem_Funct3   (ExMem_Funct3),
      .ExMem_Addr     (ExMem_Addr),
      .ExMem_WData    (ExMem_WData),
      .DMem_Req       (DMem_Req),
      .DMem_Ready     (DMem_Ready),
      .DMem_We        (DMem_We),
      .DMem_Addr      (DMem_Addr),
      .DMem_WData     (DMem_WData),
      .DMem_WStrb     (DMem_WStrb),
      .DMem_RValid    (DMem_RValid),
      .DMem_RData     (DMem_RData),
      .MemStall       (MemStall),
      .MemRData       (MemRData),
      .MisalignErr    (MisalignErr)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic idle_in();
      ExMem_MemRead  = 1'b0;
      ExMem_MemWrite = 1'b0;
      ExMem_Funct3   = 3'b000;
      ExMem_Addr     = 32'h0;
      ExMem_WData    = 32'h0;
      DMem_Ready     = 1'b0;
      DMem_RValid    = 1'b0;
      DMem_RData     = 32'h0;
   endtask

   // Minimum-latency load: req+ready, then rvalid, then done.
   task automatic load3(input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] rd, input logic [31:0] exp,
                        input string tag);
      @(negedge clk);
      idle_in();
      ExMem_MemRead = 1'b1;
      ExMem_Funct3  = f3;
      ExMem_Addr    = a;
      DMem_Ready    = 1'b1;
      #1;
      chk({tag, ":req"}, DMem_Req, 1);
      chk({tag, ":we"}, DMem_We, 0);
      chk({tag, ":addr"}, DMem_Addr, {a[31:2], 2'b00});
      chk({tag, ":strb"}, DMem_WStrb, 0);
      chk({tag, ":stall0"}, MemStall, 1);
      chk({tag, ":rdata_pre"}, MemRData, 0);
      @(negedge clk);
      DMem_Ready  = 1'b0;
      DMem_RValid = 1'b1;
      DMem_RData  = rd;
      #1;
      chk({tag, ":wait_req"}, DMem_Req, 0);
      chk({tag, ":stall1"}, MemStall, 1);
      @(negedge clk);
      DMem_RValid = 1'b0;
      #1;
      chk({tag, ":stall_done"}, MemStall, 0);
      chk({tag, ":rdata"}, MemRData, exp);
   endtask

   task automatic store3(input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] d, input logic [31:0] expw,
                         input logic [3:0] exps, input string tag);
      @(negedge clk);
      idle_in();
      ExMem_MemWrite = 1'b1;
      ExMem_Funct3   = f3;
      ExMem_Addr     = a;
      ExMem_WData    = d;
      DMem_Ready     = 1'b1;
      #1;
      chk({tag, ":req"}, DMem_Req, 1);
      chk({tag, ":we"}, DMem_We, 1);
      chk({tag, ":addr"}, DMem_Addr, {a[31:2], 2'b00});
      chk({tag, ":wdata"}, DMem_WData, expw);
      chk({tag, ":strb"}, DMem_WStrb, exps);
      @(negedge clk);
      DMem_Ready  = 1'b0;
      DMem_RValid = 1'b1;
      #1;
      chk({tag, ":stall1"}, MemStall, 1);
      @(negedge clk);
      DMem_RValid = 1'b0;
      #1;
      chk({tag, ":stall_done"}, MemStall, 0);
   endtask

   initial begin
      rst = 1'b1;
      idle_in();
      repeat (2) @(negedge clk);
      #1;
      chk("rst:req", DMem_Req, 0);
      chk("rst:we", DMem_We, 0);
      chk("rst:stall", MemStall, 0);
      chk("rst:rdata", MemRData, 0);
      chk("rst:err", MisalignErr, 0);
      chk("rst:addr", DMem_Addr, 0);
      chk("rst:strb", DMem_WStrb, 0);
      @(negedge clk);
      rst = 1'b0;

      load3(3'b010, 32'h100, 32'hDEADBEEF, 32'hDEADBEEF, "lw");
      load3(3'b000, 32'h103, 32'h80FFFFFF, 32'hFFFFFF80, "lb");
      load3(3'b100, 32'h103, 32'h80FFFFFF, 32'h00000080, "lbu");
      load3(3'b001, 32'h102, 32'h80FF1234, 32'hFFFF80FF, "lh");
      load3(3'b101, 32'h102, 32'h80FF1234, 32'h000080FF, "lhu");
      load3(3'b000, 32'h100, 32'h12345678, 32'h00000078, "lb0");
      load3(3'b001, 32'h100, 32'h12348765, 32'hFFFF8765, "lh0");

      store3(3'b000, 32'h201, 32'h0000005A, 32'h5A5A5A5A, 4'b0010, "sb");
      store3(3'b010, 32'h204, 32'hCAFEF00D, 32'hCAFEF00D, 4'b1111, "sw");
      store3(3'b001, 32'h200, 32'h00001234, 32'h12341234, 4'b0011, "sh_lo");

      // SH with Ready low for 5 cycles; EX/MEM inputs wiggle meanwhile.
      @(negedge clk);
      idle_in();
      ExMem_MemWrite = 1'b1;
      ExMem_Funct3   = 3'b001;
      ExMem_Addr     = 32'h202;
      ExMem_WData    = 32'h0000ABCD;
      for (int i = 0; i < 6; i++) begin
         if (i > 0) begin
            @(negedge clk);
            ExMem_Addr  = 32'h300;
            ExMem_WData = 32'h11110000 + i;
         end
         DMem_Ready = (i == 5);
         #1;
         chk("sh:req", DMem_Req, 1);
         chk("sh:we", DMem_We, 1);
         chk("sh:addr", DMem_Addr, 32'h200);
         chk("sh:wdata", DMem_WData, 32'hABCDABCD);
         chk("sh:strb", DMem_WStrb, 4'b1100);
         chk("sh:stall", MemStall, 1);
      end
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         DMem_Ready  = 1'b0;
         DMem_RValid = (i == 2);
         #1;
         chk("sh:wait_req", DMem_Req, 0);
         chk("sh:wait_addr", DMem_Addr, 0);
         chk("sh:wait_stall", MemStall, 1);
      end
      @(negedge clk);
      DMem_RValid = 1'b0;
      #1;
      chk("sh:done_stall", MemStall, 0);
      chk("sh:done_rdata", MemRData, 0);

      // Read and write both set: treated as a load.
      @(negedge clk);
      idle_in();
      ExMem_MemRead  = 1'b1;
      ExMem_MemWrite = 1'b1;
      ExMem_Funct3   = 3'b010;
      ExMem_Addr     = 32'h10;
      ExMem_WData    = 32'hFFFFFFFF;
      DMem_Ready     = 1'b1;
      #1;
      chk("rw:we", DMem_We, 0);
      chk("rw:strb", DMem_WStrb, 0);
      @(negedge clk);
      DMem_Ready  = 1'b0;
      DMem_RValid = 1'b1;
      DMem_RData  = 32'h00000055;
      @(negedge clk);
      DMem_RValid = 1'b0;
      #1;
      chk("rw:rdata", MemRData, 32'h55);

      // Misaligned LW: pulse error, no request, no stall.
      @(negedge clk);
      idle_in();
      ExMem_MemRead = 1'b1;
      ExMem_Funct3  = 3'b010;
      ExMem_Addr    = 32'h101;
      #1;
      chk("mis_lw:req", DMem_Req, 0);
      chk("mis_lw:err", MisalignErr, 1);
      chk("mis_lw:stall", MemStall, 0);
      chk("mis_lw:rdata", MemRData, 0);
      @(negedge clk);
      idle_in();
      #1;
      chk("mis_lw:err_clr", MisalignErr, 0);
      chk("mis_lw:req_after", DMem_Req, 0);

      // Misaligned SH and LHU.
      @(negedge clk);
      ExMem_MemWrite = 1'b1;
      ExMem_Funct3   = 3'b001;
      ExMem_Addr     = 32'h203;
      #1;
      chk("mis_sh:req", DMem_Req, 0);
      chk("mis_sh:err", MisalignErr, 1);
      @(negedge clk);
      idle_in();
      ExMem_MemRead = 1'b1;
      ExMem_Funct3  = 3'b101;
      ExMem_Addr    = 32'h101;
      #1;
      chk("mis_lhu:err", MisalignErr, 1);
      chk("mis_lhu:stall", MemStall, 0);

      // Spurious RValid while idle.
      @(negedge clk);
      idle_in();
      DMem_RValid = 1'b1;
      DMem_RData  = 32'hBAD0BAD0;
      @(negedge clk);
      DMem_RValid = 1'b0;
      #1;
      chk("spur:rdata", MemRData, 0);
      chk("spur:stall", MemStall, 0);

      // Reset in WAIT, late response ignored.
      @(negedge clk);
      idle_in();
      ExMem_MemRead = 1'b1;
      ExMem_Funct3  = 3'b010;
      ExMem_Addr    = 32'h100;
      DMem_Ready    = 1'b1;
      @(negedge clk);
      DMem_Ready = 1'b0;
      #1;
      chk("rstw:stall_wait", MemStall, 1);
      rst           = 1'b1;
      ExMem_MemRead = 1'b0;
      @(negedge clk);
      rst         = 1'b0;
      DMem_RValid = 1'b1;
      DMem_RData  = 32'h00000123;
      #1;
      chk("rstw:req", DMem_Req, 0);
      chk("rstw:stall", MemStall, 0);
      @(negedge clk);
      DMem_RValid = 1'b0;
      #1;
      chk("rstw:rdata", MemRData, 0);
      chk("rstw:stall2", MemStall, 0);

      load3(3'b010, 32'h400, 32'h0BADF00D, 32'h0BADF00D, "lw_post");

      @(negedge clk);
      idle_in();
      @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/dmem_access_unit.md
Name: dmem_access_unit

Overview:
- MEM-stage data-memory access controller for the 5-stage RV32I pipeline.
- Converts EX/MEM load/store control into a valid/ready request to a variable-latency data memory.
- Asserts a whole-pipeline freeze while an access is outstanding.
- Performs store byte-lane steering and load alignment/extension; supplies the aligned result to MEM/WB.

Parameters:
- ADDR_W, 32, byte-address width.
- DATA_W, 32, data width; fixed at 32 for RV32, with 4 byte lanes.
- TO_CYCLES, 255, watchdog limit in cycles; used only with the optional feature.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- ExMem_MemRead  in  1  load in MEM stage
- ExMem_MemWrite  in  1  store in MEM stage
- ExMem_Funct3  in  3  width/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
- ExMem_Addr  in  ADDR_W  byte address
- ExMem_WData  in  DATA_W  store data (rs2)
- DMem_Req  out  1  request valid
- DMem_Ready  in  1  memory accepts request
- DMem_We  out  1  write request
- DMem_Addr  out  ADDR_W  word-aligned address (low 2 bits forced 0)
- DMem_WData  out  DATA_W  lane-shifted store data
- DMem_WStrb  out  4  byte enables
- DMem_RValid  in  1  response valid (loads and stores)
- DMem_RData  in  DATA_W  raw word
- MemStall  out  1  freeze PC, IF/ID, ID/EX, EX/MEM; bubble MEM/WB
- MemRData  out  DATA_W  aligned, extended load result
- MisalignErr  out  1  misaligned access flag, one cycle

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high. Reset: state=IDLE, DMem_Req=0, DMem_We=0, MemRData=0, MisalignErr=0. DMem_Addr, DMem_WData and DMem_WStrb are 0 while Req=0.
- acc = ExMem_MemRead | ExMem_MemWrite. If both are high, MemRead wins.
- Misaligned: H/HU with Addr[0]=1, or W with Addr[1:0]!=0. No request issued, MisalignErr=1 for one cycle, MemStall=0, the instruction retires with MemRData=0.
- FSM states:
  - IDLE: on aligned acc, go to REQ in the same cycle. DMem_Req=1 combinationally and MemStall=1. If DMem_Ready=1 that cycle, next state is WAIT.
  - REQ: hold Req and all request fields stable until Ready=1, then go to WAIT.
  - WAIT: Req=0. On RValid, capture the load result into MemRData and go to DONE.
  - DONE: MemStall=0 for exactly one cycle so the pipeline advances and MEM/WB captures MemRData. Then go to IDLE.
- MemStall = acc & aligned & (state != DONE).
- Minimum latency: Ready and RValid arrive on consecutive cycles, giving 3 cycles per access (req, wait, done).
- A back-to-back access seen in the cycle after DONE starts a fresh transaction.
- Store steering:
  - SB: WData = {4{b}}, strobe = 1<<Addr[1:0].
  - SH: WData = {2{h}}, strobe = 0011 or 1100.
  - SW: strobe = 1111.
  - Loads use strobe = 0000.
- Load extraction: select the lane by Addr[1:0]. B/H sign-extend; BU/HU zero-extend; W passes through.
- Request fields are registered at IDLE→REQ, so they are immune to any EX/MEM change while stalled.
- DMem_RValid in IDLE or REQ is ignored as spurious; no state change.
- rst mid-transaction: return to IDLE on the next edge and drop Req. The memory-side response is discarded.

Optional Feature:
- DMEM_TIMEOUT_EN defined:
  - An 8-bit counter runs in REQ/WAIT and clears on every state change.
  - On reaching TO_CYCLES: go to DONE, MemRData=0, pulse MisalignErr=1 (reused as bus error), release the stall.
- Not defined: the unit waits indefinitely with no counter logic.

Decomposition:
- Shared package core_pkg: FSM state enum (IDLE/REQ/WAIT/DONE), FUNCT3 width constants (F3_B, F3_H, F3_W, F3_BU, F3_HU), default TO_CYCLES.
- One sub-module: dmem_lane_align, combinational store steering/strobe plus load extract/extend. It is reusable by the instruction fetch path.

Test Plan:
- LW at 0x100, Ready same cycle, RValid next cycle with 0xDEADBEEF → MemStall high for 2 cycles, then low for 1; MemRData=0xDEADBEEF; WStrb=0000.
- LB at 0x103 with RData=0x80FF_FFFF → MemRData=0xFFFFFF80. LBU at the same address → 0x00000080.
- SH at 0x202 with WData=0x0000ABCD → DMem_Addr=0x200, WData=0xABCDABCD, WStrb=1100, We=1.
- Ready held low 5 cycles, then RValid after 3 more → Req and fields stable for all 5 cycles; MemStall held for the whole transaction.
- LW at 0x101 → no Req, MisalignErr one-cycle pulse, MemStall never asserted.
- rst asserted in WAIT → next cycle state=IDLE, Req=0, MemStall=0; a late RValid is ignored. With DMEM_TIMEOUT_EN and no RValid → release after TO_CYCLES with the error pulse.
